// File: rtl/vblank_update_scheduler.sv
// Round-robin, one-hot write-access arbiter that only issues grants inside the
// vertical blanking window, with a per-grant hold limit and revoke on window close.
module vblank_update_scheduler #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_CLOSE   = 520,
  parameter int unsigned MAX_HOLD  = 4096,
  parameter int unsigned HOLD_W    = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       counter_y,
  input  logic             in_display,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             frame_tick,
  output logic             timeout_pulse,
  output logic             overrun
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned Y_W   = 10;

  typedef enum logic [1:0] {S_WAIT, S_ARB, S_GRANT} state_t;

  state_t             state, state_d;
  logic [Y_W-1:0]     prev_y;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [HOLD_W-1:0]  hold, hold_d;
  logic [N_REQ-1:0]   grant_d;
  logic               frame_tick_d;
  logic               timeout_d;

  logic               vstart;
  logic               close;
  logic               hold_last;
  logic [IDX_W-1:0]   idx_inc;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  int unsigned        sum;

  assign vstart    = (counter_y == Y_W'(V_VISIBLE)) && (prev_y != Y_W'(V_VISIBLE));
  assign close     = (counter_y == Y_W'(V_CLOSE));
  assign hold_last = (hold == HOLD_W'(MAX_HOLD - 1));
  assign idx_inc   = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);

  // Round-robin search: first requesting index at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    sum        = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = IDX_W'(sum);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    idx_d        = idx;
    hold_d       = hold;
    grant_d      = grant;
    frame_tick_d = 1'b0;
    timeout_d    = 1'b0;
    case (state)
      S_WAIT: begin
        grant_d = '0;
        if (vstart) begin
          state_d      = S_ARB;
          frame_tick_d = 1'b1;
        end
      end
      S_ARB: begin
        grant_d = '0;
        if (close) begin
          state_d = S_WAIT;
        end else if (pick_found) begin
          state_d = S_GRANT;
          idx_d   = pick_idx;
          hold_d  = '0;
          grant_d = N_REQ'(1) << pick_idx;
        end
      end
      S_GRANT: begin
        // done wins over a simultaneous close or hold timeout
        if (done[idx]) begin
          grant_d = '0;
          ptr_d   = idx_inc;
          state_d = S_ARB;
        end else if (close || in_display) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          ptr_d     = idx_inc;
          state_d   = S_WAIT;
        end else if (hold_last) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          ptr_d     = idx_inc;
          state_d   = S_ARB;
        end else if (hold != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold + HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_WAIT;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_WAIT;
      prev_y        <= '0;
      ptr           <= '0;
      idx           <= '0;
      hold          <= '0;
      grant         <= '0;
      grant_valid   <= 1'b0;
      frame_tick    <= 1'b0;
      timeout_pulse <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_d;
      prev_y        <= counter_y;
      ptr           <= ptr_d;
      idx           <= idx_d;
      hold          <= hold_d;
      grant         <= grant_d;
      grant_valid   <= |grant_d;
      frame_tick    <= frame_tick_d;
      timeout_pulse <= timeout_d;
      overrun       <= overrun | (in_display & grant_valid);
    end
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler; counter_y/in_display are driven
// directly with a compressed line timing.
module tb_vblank_update_scheduler;

  logic       clk;
  logic       reset;
  logic [9:0] counter_y;
  logic       in_display;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic       grant_valid;
  logic       frame_tick;
  logic       timeout_pulse;
  logic       overrun;

  int tests;
  int fails;

  vblank_update_scheduler #(
    .N_REQ(3), .V_VISIBLE(480), .V_CLOSE(520), .MAX_HOLD(16), .HOLD_W(5)
  ) dut (
    .clk(clk), .reset(reset), .counter_y(counter_y), .in_display(in_display),
    .req(req), .done(done), .grant(grant), .grant_valid(grant_valid),
    .frame_tick(frame_tick), .timeout_pulse(timeout_pulse), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; done = '0; counter_y = '0; in_display = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Leaves the DUT in ARB with frame_tick just observed.
  task automatic enter_window();
    counter_y = 10'd479; in_display = 1'b1;
    tick();
    counter_y = 10'd480; in_display = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL reset_grant: got %b expected 000", grant); end
    tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL reset_grant_valid: got %b expected 0", grant_valid); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick); end
    tests++; if (timeout_pulse !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout_pulse); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_frame_tick();
    int ticks = 0;
    int bad_tick = 0;
    int bad_grant = 0;
    bit exp_tick;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int y = 470; y <= 524; y++) begin
        for (int c = 0; c < 3; c++) begin
          counter_y = 10'(y); in_display = (y < 480);
          tick();
          exp_tick = (y == 480) && (c == 0);
          if (frame_tick) ticks++;
          if (frame_tick !== exp_tick) bad_tick++;
          if (grant !== 3'b000) bad_grant++;
        end
      end
    end
    tests++; if (ticks !== 2) begin fails++; $display("FAIL frame_tick_count: got %0d expected 2", ticks); end
    tests++; if (bad_tick !== 0) begin fails++; $display("FAIL frame_tick_timing: got %0d misplaced expected 0", bad_tick); end
    tests++; if (bad_grant !== 0) begin fails++; $display("FAIL idle_grant: got %0d grant cycles expected 0", bad_grant); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [4];
    int n = 0;
    int run = 0;
    int gap = 0;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    do_reset();
    enter_window();
    req = 3'b111;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (grant !== 3'b000) begin
        if (run == 0) begin
          tests++; if (grant !== exp_seq[n]) begin fails++; $display("FAIL rr_grant%0d: got %b expected %b", n, grant, exp_seq[n]); end
          if (n > 0) begin
            tests++; if (gap !== 1) begin fails++; $display("FAIL rr_gap%0d: got %0d expected 1", n, gap); end
          end
        end
        run++;
        gap = 0;
        done = (run == 5) ? grant : 3'b000;
      end else begin
        if (run != 0) begin
          tests++; if (run !== 5) begin fails++; $display("FAIL rr_len%0d: got %0d expected 5", n, run); end
          n++;
          run = 0;
        end
        gap++;
        done = 3'b000;
      end
    end
    done = '0; req = '0;
    tests++; if (n !== 4) begin fails++; $display("FAIL rr_count: got %0d grants expected 4", n); end
  endtask

  task automatic test_hold_timeout();
    int n = 0;
    int tbad = 0;
    do_reset();
    enter_window();
    req = 3'b010;
    tick();
    while (grant === 3'b010 && n < 40) begin
      n++;
      if (timeout_pulse) tbad++;
      tick();
    end
    tests++; if (n !== 16) begin fails++; $display("FAIL hold_len: got %0d expected 16", n); end
    tests++; if (tbad !== 0) begin fails++; $display("FAIL hold_early_timeout: got %0d expected 0", tbad); end
    tests++; if (timeout_pulse !== 1'b1) begin fails++; $display("FAIL hold_timeout: got %b expected 1", timeout_pulse); end
    tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL hold_drop_valid: got %b expected 0", grant_valid); end
    tick();
    tests++; if (grant !== 3'b010) begin fails++; $display("FAIL hold_regrant: got %b expected 010", grant); end
    tests++; if (timeout_pulse !== 1'b0) begin fails++; $display("FAIL hold_timeout_once: got %b expected 0", timeout_pulse); end
    req = '0;
  endtask

  task automatic test_close();
    int bad = 0;
    do_reset();
    enter_window();
    req = 3'b001;
    tick();
    tests++; if (grant !== 3'b001) begin fails++; $display("FAIL close_grant: got %b expected 001", grant); end
    req = 3'b000; done = 3'b100;
    tick();
    done = 3'b000;
    tests++; if (grant !== 3'b001) begin fails++; $display("FAIL foreign_done: got %b expected 001", grant); end
    tick();
    tests++; if (grant !== 3'b001) begin fails++; $display("FAIL req_drop_hold: got %b expected 001", grant); end
    counter_y = 10'd520;
    tick();
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL close_drop: got %b expected 000", grant); end
    tests++; if (timeout_pulse !== 1'b1) begin fails++; $display("FAIL close_timeout: got %b expected 1", timeout_pulse); end
    req = 3'b001;
    tick();
    tests++; if (timeout_pulse !== 1'b0) begin fails++; $display("FAIL close_timeout_once: got %b expected 0", timeout_pulse); end
    for (int y = 521; y <= 524; y++) begin
      counter_y = 10'(y); in_display = 1'b0;
      tick();
      if (grant !== 3'b000 || frame_tick !== 1'b0) bad++;
    end
    for (int y = 470; y <= 479; y++) begin
      counter_y = 10'(y); in_display = 1'b1;
      tick();
      if (grant !== 3'b000 || frame_tick !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL close_no_grant: got %0d bad cycles expected 0", bad); end
    counter_y = 10'd480; in_display = 1'b0;
    tick();
    tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL next_frame_tick: got %b expected 1", frame_tick); end
    tick();
    tests++; if (grant !== 3'b001) begin fails++; $display("FAIL next_frame_grant: got %b expected 001", grant); end
    req = '0;
  endtask

  task automatic test_done_vs_close();
    do_reset();
    enter_window();
    req = 3'b001;
    tick();
    tests++; if (grant !== 3'b001) begin fails++; $display("FAIL dvc_grant: got %b expected 001", grant); end
    done = 3'b001; counter_y = 10'd520;
    tick();
    done = 3'b000;
    tests++; if (timeout_pulse !== 1'b0) begin fails++; $display("FAIL dvc_timeout: got %b expected 0", timeout_pulse); end
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL dvc_drop: got %b expected 000", grant); end
    counter_y = 10'd521; req = 3'b011;
    tick();
    tests++; if (grant !== 3'b010) begin fails++; $display("FAIL dvc_pointer: got %b expected 010", grant); end
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    enter_window();
    req = 3'b001;
    tick();
    reset = 1'b1;
    tick();
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL rmg_grant: got %b expected 000", grant); end
    tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL rmg_valid: got %b expected 0", grant_valid); end
    tests++; if (timeout_pulse !== 1'b0) begin fails++; $display("FAIL rmg_timeout: got %b expected 0", timeout_pulse); end
    reset = 1'b0;
    tick();
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL rmg_wait: got %b expected 000", grant); end
    req = '0;
  endtask

  task automatic test_overrun();
    do_reset();
    enter_window();
    req = 3'b100;
    tick();
    tests++; if (grant !== 3'b100) begin fails++; $display("FAIL ovr_grant: got %b expected 100", grant); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_pre: got %b expected 0", overrun); end
    in_display = 1'b1;
    tick();
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL ovr_drop: got %b expected 000", grant); end
    tests++; if (timeout_pulse !== 1'b1) begin fails++; $display("FAIL ovr_timeout: got %b expected 1", timeout_pulse); end
    in_display = 1'b0;
    tick();
    tests++; if (timeout_pulse !== 1'b0) begin fails++; $display("FAIL ovr_timeout_once: got %b expected 0", timeout_pulse); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    req = '0;
  endtask

  initial begin
    clk = 1'b0;
    tests = 0;
    fails = 0;
    reset = 1'b1; req = '0; done = '0; counter_y = '0; in_display = 1'b0;
    test_reset();
    test_frame_tick();
    test_round_robin();
    test_hold_timeout();
    test_close();
    test_done_vs_close();
    test_reset_mid_grant();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
